// File: rtl/stopwatch_pkg.sv
// Purpose: shared state encodings and BCD limits for the stopwatch core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_ZERO     = 4'd0;
    localparam logic [BCD_W-1:0] BCD_ONE      = 4'd1;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_pair.sv
// Purpose: two-digit BCD counter with a programmable top value, wrap or hold at the top.
// Latency: digits update on the clock edge that samples inc.
// Backpressure: none; every inc pulse is consumed the cycle it arrives.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears both digits)
//   inc                 1-cycle increment request
//   tens_max, ones_max  top value of the pair (e.g. 5/9 for seconds)
//   sat                 0 = wrap top -> 00, 1 = hold at top
//   tens, ones          registered BCD digits
//   carry_out           inc seen while the pair sits at its top value
module bcd_digit_pair
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [BCD_W-1:0] tens_max,
    input  logic [BCD_W-1:0] ones_max,
    input  logic             sat,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry_out
);

    logic at_max;

    assign at_max    = (tens == tens_max) && (ones == ones_max);
    assign carry_out = inc && at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= BCD_ZERO;
            ones <= BCD_ZERO;
        end else if (inc) begin
            if (at_max) begin
                if (!sat) begin
                    tens <= BCD_ZERO;
                    ones <= BCD_ZERO;
                end
            end else if (ones == DIGIT_MAX) begin
                ones <= BCD_ZERO;
                tens <= tens + BCD_ONE;
            end else begin
                ones <= ones + BCD_ONE;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Purpose: MM:SS BCD stopwatch core with run/pause FSM and fast-set adjust mode.
// Latency: 1 clk from an enable pulse to the new digit value / rollover / running.
// Backpressure: none; enable and pause pulses act in the cycle they are sampled.
//
// Ports:
//   clk, rst                synchronous active-high reset, overrides all inputs
//   one_hz_en, two_hz_en    1-cycle divider pulses (count tick / adjust tick)
//   pause_pulse             debounced press, toggles RUN/PAUSED
//   adj, sel                adjust mode level; field select (0 = minutes, 1 = seconds)
//   min_tens..sec_ones      registered BCD digits
//   running                 1 while in RUN
//   rollover                1-clk pulse on MIN_LIMIT:59 -> 00:00 in count mode
// Build option: STOPWATCH_SAT_EN defined -> count mode holds at MIN_LIMIT:59 and
// pauses instead of wrapping; rollover is then tied 0.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT     = 99,
    parameter bit RESET_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             one_hz_en,
    input  logic             two_hz_en,
    input  logic             pause_pulse,
    input  logic             adj,
    input  logic             sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             rollover
);

    localparam logic [BCD_W-1:0] MIN_TENS_MAX = BCD_W'(MIN_LIMIT / 10);
    localparam logic [BCD_W-1:0] MIN_ONES_MAX = BCD_W'(MIN_LIMIT % 10);
    localparam state_t           RESET_STATE  = RESET_RUNNING ? ST_RUN : ST_PAUSED;

    state_t state;
    state_t state_nxt;

    logic is_run;
    logic count_tick;
    logic adj_tick;
    logic limit_hold;
    logic roll_nxt;
    logic sec_inc;
    logic sec_carry;
    logic min_inc;
    logic min_carry;

    // Mode muxing: only the pulse belonging to the current mode acts, and
    // only while running. Decisions use the current state, so a pause press
    // in the same cycle as a tick still lets that tick count.
    assign is_run     = (state == ST_RUN);
    assign count_tick = is_run && !adj && one_hz_en;
    assign adj_tick   = is_run &&  adj && two_hz_en;

`ifdef STOPWATCH_SAT_EN
    logic at_limit;
    assign at_limit   = (sec_tens == SEC_TENS_MAX) && (sec_ones == SEC_ONES_MAX) &&
                        (min_tens == MIN_TENS_MAX) && (min_ones == MIN_ONES_MAX);
    assign limit_hold = count_tick && at_limit;
    assign roll_nxt   = 1'b0;
`else
    assign limit_hold = 1'b0;
    // A minute carry outside adjust mode can only come from MIN_LIMIT:59 wrapping.
    assign roll_nxt   = min_carry && !adj;
`endif

    assign sec_inc = (count_tick && !limit_hold) || (adj_tick && sel);
    // Seconds carry feeds minutes only in count mode; adjusting seconds never carries.
    assign min_inc = (count_tick && sec_carry) || (adj_tick && !sel);

    // Both pairs wrap. Count-mode saturation is done by gating the increment
    // above, since seconds must still wrap 59 -> 00 below the minute limit.
    bcd_digit_pair u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc),
        .tens_max  (SEC_TENS_MAX),
        .ones_max  (SEC_ONES_MAX),
        .sat       (1'b0),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    bcd_digit_pair u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc),
        .tens_max  (MIN_TENS_MAX),
        .ones_max  (MIN_ONES_MAX),
        .sat       (1'b0),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry)
    );

    always_comb begin
        state_nxt = state;
        if (pause_pulse) begin
            state_nxt = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
        // Reaching the saturated limit always parks the FSM, whatever the press.
        if (limit_hold) begin
            state_nxt = ST_PAUSED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_STATE;
            rollover <= 1'b0;
        end else begin
            state    <= state_nxt;
            rollover <= roll_nxt;
        end
    end

    assign running = is_run;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose: directed self-checking bench for stopwatch_counter (MIN_LIMIT 99 and 9 builds).
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: n/a.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, one_hz_en, two_hz_en, pause_pulse, adj, sel;

    logic [3:0] a_mt, a_mo, a_st, a_so;
    logic       a_running, a_rollover;
    logic [3:0] b_mt, b_mo, b_st, b_so;
    logic       b_running, b_rollover;

    stopwatch_counter #(.MIN_LIMIT(99), .RESET_RUNNING(1'b1)) dut_a (
        .clk(clk), .rst(rst), .one_hz_en(one_hz_en), .two_hz_en(two_hz_en),
        .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
        .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
        .running(a_running), .rollover(a_rollover)
    );

    stopwatch_counter #(.MIN_LIMIT(9), .RESET_RUNNING(1'b0)) dut_b (
        .clk(clk), .rst(rst), .one_hz_en(one_hz_en), .two_hz_en(two_hz_en),
        .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
        .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
        .running(b_running), .rollover(b_rollover)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic ro_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // MM:SS packed as a decimal number mmss for compact comparisons.
    function automatic logic [31:0] a_mmss();
        return a_mt * 1000 + a_mo * 100 + a_st * 10 + a_so;
    endfunction

    function automatic logic [31:0] b_mmss();
        return b_mt * 1000 + b_mo * 100 + b_st * 10 + b_so;
    endfunction

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) one_hz_en = 1'b1;
            @(negedge clk) one_hz_en = 1'b0;
            if (a_rollover === 1'b1) ro_seen = 1'b1;
        end
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) two_hz_en = 1'b1;
            @(negedge clk) two_hz_en = 1'b0;
        end
    endtask

    task automatic press_pause();
        @(negedge clk) pause_pulse = 1'b1;
        @(negedge clk) pause_pulse = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; one_hz_en = 1'b0; two_hz_en = 1'b0;
        pause_pulse = 1'b0; adj = 1'b0; sel = 1'b0;
        ro_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_a_digits", a_mmss(), 0);
        check("rst_a_running", a_running, 1);
        check("rst_a_rollover", a_rollover, 0);
        check("rst_b_digits", b_mmss(), 0);
        check("rst_b_running", b_running, 0);

        // 1: 61 seconds counts to 01:01, no rollover
        tick1(61);
        check("t1_digits", a_mmss(), 101);
        check("t1_running", a_running, 1);
        check("t1_no_rollover", ro_seen, 0);
        tick2(1);
        check("t1_2hz_ignored", a_mmss(), 101);

        // 2: preset 99:59 via adjust, then one count tick
        adj = 1'b1; sel = 1'b0;
        tick2(98);
        sel = 1'b1;
        tick2(58);
        check("t2_preset", a_mmss(), 9959);
        adj = 1'b0;
        @(negedge clk) one_hz_en = 1'b1;
        @(negedge clk) one_hz_en = 1'b0;
`ifndef STOPWATCH_SAT_EN
        check("t2_wrap_digits", a_mmss(), 0);
        check("t2_rollover_high", a_rollover, 1);
        check("t2_running", a_running, 1);
        @(negedge clk);
        check("t2_rollover_low", a_rollover, 0);
`else
        check("t2_sat_digits", a_mmss(), 9959);
        check("t2_sat_running", a_running, 0);
        check("t2_sat_rollover", a_rollover, 0);
        tick1(1);
        check("t2_sat_hold", a_mmss(), 9959);
`endif

        // 3: seconds adjust wraps without carry; 1 Hz ignored in adjust
        do_reset();
        check("t3_running", a_running, 1);
        adj = 1'b1; sel = 1'b1;
        tick2(58);
        check("t3_start", a_mmss(), 58);
        tick2(3);
        check("t3_wrap", a_mmss(), 1);
        tick1(1);
        check("t3_1hz_ignored", a_mmss(), 1);

        // 4: tick and pause in the same cycle, then frozen while paused
        tick2(9);
        adj = 1'b0;
        check("t4_start", a_mmss(), 10);
        @(negedge clk) begin pause_pulse = 1'b1; one_hz_en = 1'b1; end
        @(negedge clk) begin pause_pulse = 1'b0; one_hz_en = 1'b0; end
        check("t4_tick_then_pause", a_mmss(), 11);
        check("t4_paused", a_running, 0);
        tick1(5);
        check("t4_frozen", a_mmss(), 11);
        adj = 1'b1;
        tick2(2);
        check("t4_adj_frozen", a_mmss(), 11);
        adj = 1'b0;
        press_pause();
        check("t4_resume", a_running, 1);

        // 5: reset coincident with a tick at 12:34
        adj = 1'b1; sel = 1'b0;
        tick2(12);
        sel = 1'b1;
        tick2(23);
        adj = 1'b0;
        check("t5_start", a_mmss(), 1234);
        @(negedge clk) begin rst = 1'b1; one_hz_en = 1'b1; end
        @(negedge clk) begin rst = 1'b0; one_hz_en = 1'b0; end
        check("t5_digits", a_mmss(), 0);
        check("t5_running", a_running, 1);
        check("t5_rollover", a_rollover, 0);
        check("t5_b_running", b_running, 0);

        // 6: MIN_LIMIT = 9 minute adjust wraps 09 -> 00
        press_pause();
        check("t6_b_running", b_running, 1);
        adj = 1'b1; sel = 1'b0;
        tick2(9);
        check("t6_b_at_limit", b_mmss(), 900);
        tick2(1);
        check("t6_b_wrap", b_mmss(), 0);
        tick2(9);
        sel = 1'b1;
        tick2(59);
        check("t6_b_preset", b_mmss(), 959);
        adj = 1'b0;
        @(negedge clk) one_hz_en = 1'b1;
        @(negedge clk) one_hz_en = 1'b0;
`ifndef STOPWATCH_SAT_EN
        check("t6_b_count_wrap", b_mmss(), 0);
        check("t6_b_rollover", b_rollover, 1);
`else
        check("t6_b_count_hold", b_mmss(), 959);
        check("t6_b_sat_running", b_running, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
